// File: rtl/pipe_cond_unit_d_to_e.sv
// pipe_cond_unit_d_to_e: D->E pipeline register with NZCV flags and ARM condition evaluation.
// COND_NV_UNDEF_EN: when defined, UndefE flags a valid E instruction whose condition is 1111.
module pipe_cond_unit_d_to_e (
  input  logic       clk,
  input  logic       rst,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic [1:0] ALUControlD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlags,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemtoRegE,
  output logic       MemWriteE,
  output logic       BranchTakenE,
  output logic       ALUSrcE,
  output logic [1:0] ALUControlE,
  output logic       CondExE,
  output logic [3:0] FlagsE,
  output logic       UndefE
);
  logic       pcSrcR, regWriteR, memWriteR, branchR;
  logic [1:0] flagWriteE;
  logic [3:0] condE;
  logic       n, z, c, v;

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      pcSrcR      <= 1'b0;
      regWriteR   <= 1'b0;
      MemtoRegE   <= 1'b0;
      memWriteR   <= 1'b0;
      branchR     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= 2'b00;
      flagWriteE  <= 2'b00;
      condE       <= 4'b1110;
    end else if (!StallE) begin
      pcSrcR      <= PCSrcD;
      regWriteR   <= RegWriteD;
      MemtoRegE   <= MemtoRegD;
      memWriteR   <= MemWriteD;
      branchR     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ALUControlE <= ALUControlD;
      flagWriteE  <= FlagWriteD;
      condE       <= CondD;
    end
  end

  // flush kills the incoming instruction only, so the leaving one still writes flags
  always_ff @(posedge clk) begin
    if (rst)
      FlagsE <= 4'b0000;
    else if (!StallE && CondExE)
      FlagsE <= {flagWriteE[1] ? ALUFlags[3:2] : FlagsE[3:2],
                 flagWriteE[0] ? ALUFlags[1:0] : FlagsE[1:0]};
  end

  assign {n, z, c, v} = FlagsE;

  always_comb begin
    CondExE = 1'b0;
    case (condE)
      4'b0000: CondExE = z;
      4'b0001: CondExE = !z;
      4'b0010: CondExE = c;
      4'b0011: CondExE = !c;
      4'b0100: CondExE = n;
      4'b0101: CondExE = !n;
      4'b0110: CondExE = v;
      4'b0111: CondExE = !v;
      4'b1000: CondExE = c && !z;
      4'b1001: CondExE = !c || z;
      4'b1010: CondExE = n == v;
      4'b1011: CondExE = n != v;
      4'b1100: CondExE = !z && (n == v);
      4'b1101: CondExE = z || (n != v);
      4'b1110: CondExE = 1'b1;
      default: CondExE = 1'b0;
    endcase
  end

  assign PCSrcE       = pcSrcR && CondExE;
  assign RegWriteE    = regWriteR && CondExE;
  assign MemWriteE    = memWriteR && CondExE;
  assign BranchTakenE = branchR && CondExE;

`ifdef COND_NV_UNDEF_EN
  logic validE;
  always_ff @(posedge clk) begin
    if (rst || FlushE)
      validE <= 1'b0;
    else if (!StallE)
      validE <= 1'b1;
  end
  assign UndefE = validE && (condE == 4'b1111);
`else
  assign UndefE = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_cond_unit_d_to_e.sv
// tb_pipe_cond_unit_d_to_e: scoreboard bench with directed phases and random traffic.
module tb_pipe_cond_unit_d_to_e;
  typedef struct packed {
    logic       pcSrc, regWrite, memtoReg, memWrite, branch, aluSrc;
    logic [1:0] aluCtl;
    logic [1:0] flagWrite;
    logic [3:0] cond;
  } dIn_t;
  typedef struct packed {
    logic [7:0] ctrl;
    logic       cx;
    logic [3:0] flags;
    logic       undef;
  } exp_t;

  logic clk = 1'b0, rst, StallE, FlushE;
  logic PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
  logic [1:0] ALUControlD, FlagWriteD;
  logic [3:0] CondD, ALUFlags;
  logic PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchTakenE, ALUSrcE, CondExE, UndefE;
  logic [1:0] ALUControlE;
  logic [3:0] FlagsE;

  pipe_cond_unit_d_to_e dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD),
    .CondD(CondD), .ALUFlags(ALUFlags),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchTakenE(BranchTakenE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .CondExE(CondExE), .FlagsE(FlagsE), .UndefE(UndefE)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t got;
  int vectors = 0, miscompares = 0;
  localparam dIn_t BUBBLE = dIn_t'(14'h000e);
  dIn_t mE = BUBBLE;
  logic mValid = 1'b0;
  logic [3:0] mFlags = 4'b0000;

  // ARM rule: cond[3:1] picks a test, cond[0] inverts it; 111 is "always", so 1111 becomes never
  function automatic logic holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = n == v;
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("ctrl", {PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchTakenE, ALUSrcE, ALUControlE}, got.ctrl);
      check("CondExE", {7'd0, CondExE}, {7'd0, got.cx});
      check("FlagsE", {4'd0, FlagsE}, {4'd0, got.flags});
      check("UndefE", {7'd0, UndefE}, {7'd0, got.undef});
    end
  end

  task automatic step(input dIn_t d, input logic s, input logic f, input logic r, input logic [3:0] a);
    exp_t e;
    logic cx;
    @(negedge clk);
    {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, ALUControlD, FlagWriteD, CondD} = d;
    StallE = s; FlushE = f; rst = r; ALUFlags = a;
    if (r) begin
      mFlags = 4'b0000; mE = BUBBLE; mValid = 1'b0;
    end else begin
      if (!s && holds(mE.cond, mFlags))
        mFlags = {mE.flagWrite[1] ? a[3:2] : mFlags[3:2], mE.flagWrite[0] ? a[1:0] : mFlags[1:0]};
      if (f) begin
        mE = BUBBLE; mValid = 1'b0;
      end else if (!s) begin
        mE = d; mValid = 1'b1;
      end
    end
    cx = holds(mE.cond, mFlags);
    e.cx = cx;
    e.flags = mFlags;
    e.ctrl = {mE.pcSrc & cx, mE.regWrite & cx, mE.memWrite & cx, mE.memtoReg,
              mE.branch & cx, mE.aluSrc, mE.aluCtl};
`ifdef COND_NV_UNDEF_EN
    e.undef = mValid && mE.cond == 4'hf;
`else
    e.undef = 1'b0;
`endif
    sb.push_back(e);
  endtask

  // build an instruction: bits = {pcSrc,regWrite,memtoReg,memWrite,branch,aluSrc}
  function automatic dIn_t ins(input logic [5:0] bits, input logic [1:0] fw, input logic [3:0] cond);
    return dIn_t'({bits, 2'b00, fw, cond});
  endfunction

  initial begin
    step(dIn_t'(14'h3fff), 1, 1, 1, 4'hf);
    step(dIn_t'(14'h3fff), 1, 1, 1, 4'hf);
    step(ins(6'b000000, 2'b11, 4'he), 0, 0, 0, 4'h0);
    step(ins(6'b010000, 2'b00, 4'h0), 0, 0, 0, 4'h4);
    step(ins(6'b010000, 2'b11, 4'h1), 0, 0, 0, 4'hb);
    step(ins(6'b000000, 2'b11, 4'he), 0, 0, 0, 4'hb);
    step(ins(6'b000000, 2'b01, 4'he), 0, 0, 0, 4'hf);
    step(ins(6'b000000, 2'b11, 4'he), 0, 0, 0, 4'h0);
    step(ins(6'b111111, 2'b11, 4'he), 1, 0, 0, 4'h6);
    step(ins(6'b111111, 2'b11, 4'he), 1, 0, 0, 4'h6);
    step(ins(6'b111111, 2'b11, 4'he), 1, 0, 0, 4'h6);
    step(ins(6'b111111, 2'b00, 4'he), 0, 0, 0, 4'h9);
    step(ins(6'b111111, 2'b00, 4'he), 1, 1, 0, 4'h3);
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++) begin
        step(ins(6'b000000, 2'b11, 4'he), 0, 0, 0, 4'(c));
        step(ins(6'b000010, 2'b00, 4'(c)), 0, 0, 0, 4'(f));
      end
    step(ins(6'b000100, 2'b00, 4'hf), 0, 0, 0, 4'h0);
    step(ins(6'b000100, 2'b00, 4'hf), 0, 0, 0, 4'h0);
    step(ins(6'b000100, 2'b00, 4'hf), 0, 1, 0, 4'h0);
    step(ins(6'b000100, 2'b00, 4'hf), 1, 0, 0, 4'h0);
    step(ins(6'b000100, 2'b11, 4'he), 1, 0, 1, 4'h0);
    for (int i = 0; i < 2000; i++)
      step(dIn_t'(14'($urandom_range(0, 16383))), $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, 4'($urandom_range(0, 15)));
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
